reg_file_mp: RTL and testbench

//   Parametrised multi-port integer register file for the RV32IM ID/RF stage.
//   - Port A: single-cycle write-back. Port B: long-latency MUL/DIV write-back.
//   - NUM_RD combinational read ports; x0 is hard-wired to zero.
//   - Per-register busy scoreboard, so ID stalls on operands still owed by the M unit.

---
 rtl/reg_file_mp.sv | 74 +++++++
 tb/tb_reg_file_mp.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port RV32IM register file with M-unit busy scoreboard
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         WRITE_ENABLE,
  input  logic [ADDR_WIDTH-1:0]        WRITE_ADDR,
  input  logic [DATA_WIDTH-1:0]        WRITE_DATA,
  input  logic                         WRITE_ENABLE2,
  input  logic [ADDR_WIDTH-1:0]        WRITE_ADDR2,
  input  logic [DATA_WIDTH-1:0]        WRITE_DATA2,
  input  logic                         BUSY_SET,
  input  logic [ADDR_WIDTH-1:0]        BUSY_ADDR,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] OUT_ADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0] DATA_OUT,
  output logic [NUM_RD-1:0]            BUSY_OUT,
  output logic                         WRITE_CONFLICT
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;

  logic wr_a, wr_b, collide;
  always_comb begin
    wr_a    = WRITE_ENABLE  && (WRITE_ADDR  != '0);
    wr_b    = WRITE_ENABLE2 && (WRITE_ADDR2 != '0);
    collide = wr_a && wr_b && (WRITE_ADDR == WRITE_ADDR2);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      busy           <= '0;
      WRITE_CONFLICT <= 1'b0;
    end else begin
      if (wr_a) regs[WRITE_ADDR] <= WRITE_DATA;
      // Port B loses a collision, but its busy clear below still happens.
      if (wr_b && !collide) regs[WRITE_ADDR2] <= WRITE_DATA2;
      WRITE_CONFLICT <= collide;
      for (int r = 1; r < DEPTH; r++) begin
        if (BUSY_SET && (BUSY_ADDR == ADDR_WIDTH'(r)))
          busy[r] <= 1'b1;
        else if (WRITE_ENABLE2 && (WRITE_ADDR2 == ADDR_WIDTH'(r)))
          busy[r] <= 1'b0;
      end
      busy[0] <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    always_comb begin
      ra = OUT_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      rd = regs[ra];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_a && (WRITE_ADDR == ra))
        rd = WRITE_DATA;
      else if (wr_b && (WRITE_ADDR2 == ra))
        rd = WRITE_DATA2;
`endif
      if (ra == '0) rd = '0;
    end
    assign DATA_OUT[i*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign BUSY_OUT[i] = (ra != '0) && busy[ra];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        WRITE_ENABLE = 1'b0;
  logic [4:0]  WRITE_ADDR = '0;
  logic [31:0] WRITE_DATA = '0;
  logic        WRITE_ENABLE2 = 1'b0;
  logic [4:0]  WRITE_ADDR2 = '0;
  logic [31:0] WRITE_DATA2 = '0;
  logic        BUSY_SET = 1'b0;
  logic [4:0]  BUSY_ADDR = '0;
  logic [9:0]  OUT_ADDR = '0;
  logic [63:0] DATA_OUT;
  logic [1:0]  BUSY_OUT;
  logic        WRITE_CONFLICT;

  int checks = 0;
  int errors = 0;

  reg_file_mp dut (
    .CLK(CLK), .RESET(RESET),
    .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
    .WRITE_ENABLE2(WRITE_ENABLE2), .WRITE_ADDR2(WRITE_ADDR2), .WRITE_DATA2(WRITE_DATA2),
    .BUSY_SET(BUSY_SET), .BUSY_ADDR(BUSY_ADDR),
    .OUT_ADDR(OUT_ADDR), .DATA_OUT(DATA_OUT), .BUSY_OUT(BUSY_OUT),
    .WRITE_CONFLICT(WRITE_CONFLICT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    OUT_ADDR = {a1, a0};
    #1;
  endtask

  task automatic idle();
    WRITE_ENABLE = 1'b0; WRITE_ENABLE2 = 1'b0; BUSY_SET = 1'b0;
  endtask

  initial begin
    tick();
    // 1: x5 <= 7, then reset with a busy set pending
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd5; WRITE_DATA = 32'd7;
    tick(); idle();
    rd(5'd5, 5'd0);
    check("pre_reset_x5", DATA_OUT[31:0], 32'd7);
    RESET = 1'b0; BUSY_SET = 1'b1; BUSY_ADDR = 5'd5;
    tick(); tick();
    RESET = 1'b1; idle();
    rd(5'd5, 5'd1);
    check("reset_x5", DATA_OUT[31:0], 32'd0);
    check("reset_busy", {30'd0, BUSY_OUT}, 32'd0);
    check("reset_conflict", {31'd0, WRITE_CONFLICT}, 32'd0);

    // 2: A x1<=42, B x2<=100 same cycle
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd1; WRITE_DATA = 32'd42;
    WRITE_ENABLE2 = 1'b1; WRITE_ADDR2 = 5'd2; WRITE_DATA2 = 32'd100;
    tick(); idle();
    rd(5'd1, 5'd2);
    check("dual_x1", DATA_OUT[31:0], 32'd42);
    check("dual_x2", DATA_OUT[63:32], 32'd100);
    check("dual_no_conflict", {31'd0, WRITE_CONFLICT}, 32'd0);
    rd(5'd0, 5'd2);
    check("read_x0", DATA_OUT[31:0], 32'd0);

    // 3: write to x0 ignored
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd0; WRITE_DATA = 32'd123;
    tick(); idle();
    rd(5'd0, 5'd1);
    check("x0_after_write", DATA_OUT[31:0], 32'd0);
    check("x1_unchanged", DATA_OUT[63:32], 32'd42);

    // 4: collision on x3
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd3; WRITE_DATA = 32'd11;
    WRITE_ENABLE2 = 1'b1; WRITE_ADDR2 = 5'd3; WRITE_DATA2 = 32'd22;
    tick(); idle();
    rd(5'd3, 5'd0);
    check("collide_x3", DATA_OUT[31:0], 32'd11);
    check("conflict_set", {31'd0, WRITE_CONFLICT}, 32'd1);
    tick();
    check("conflict_clear", {31'd0, WRITE_CONFLICT}, 32'd0);

    // 5: scoreboard
    BUSY_SET = 1'b1; BUSY_ADDR = 5'd4;
    tick(); idle();
    rd(5'd4, 5'd0);
    check("busy_x4_set", {30'd0, BUSY_OUT}, 32'd1);
    WRITE_ENABLE2 = 1'b1; WRITE_ADDR2 = 5'd4; WRITE_DATA2 = 32'd9;
    #1;
    check("busy_x4_not_bypassed", {30'd0, BUSY_OUT}, 32'd1);
    tick(); idle();
    #1;
    check("busy_x4_clear", {30'd0, BUSY_OUT}, 32'd0);
    check("x4_data", DATA_OUT[31:0], 32'd9);
    BUSY_SET = 1'b1; BUSY_ADDR = 5'd6;
    WRITE_ENABLE2 = 1'b1; WRITE_ADDR2 = 5'd6; WRITE_DATA2 = 32'd77;
    tick(); idle();
    rd(5'd6, 5'd4);
    check("busy_x6_set_wins", {30'd0, BUSY_OUT}, 32'd1);
    check("x6_data", DATA_OUT[31:0], 32'd77);
    BUSY_SET = 1'b1; BUSY_ADDR = 5'd6;
    tick(); idle();
    #1;
    check("busy_x6_reset_again", {30'd0, BUSY_OUT}, 32'd1);
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd6; WRITE_DATA = 32'd5;
    tick(); idle();
    #1;
    check("busy_x6_port_a_no_clear", {30'd0, BUSY_OUT}, 32'd1);

    // 6: same-cycle read of a port A write
    rd(5'd7, 5'd6);
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd7; WRITE_DATA = 32'd55;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("bypass_x7_before", DATA_OUT[31:0], 32'd55);
`else
    check("bypass_x7_before", DATA_OUT[31:0], 32'd0);
`endif
    tick(); idle();
    #1;
    check("bypass_x7_after", DATA_OUT[31:0], 32'd55);

    // reset mid-M-op overrides a concurrent write
    RESET = 1'b0;
    WRITE_ENABLE = 1'b1; WRITE_ADDR = 5'd8; WRITE_DATA = 32'd99;
    tick();
    RESET = 1'b1; idle();
    rd(5'd6, 5'd8);
    check("reset_mid_op_busy", {30'd0, BUSY_OUT}, 32'd0);
    check("reset_mid_op_x8", DATA_OUT[63:32], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
